// File: rtl/elu_lut_index.sv
// elu_lut_index: floor-shift and clamp of PAR fixed-point activations
// into signed LUT addresses, behind a 2-stage valid/ready pipeline.
module elu_lut_index #(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 8,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
    parameter int LUT_ADDR_WIDTH              = 2,
    parameter int LUT_ADDR_FRAC               = 0,
    parameter int SAT_CNT_WIDTH               = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PRECISION_0-1:0] data_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    output logic [DATA_IN_0_PARALLELISM_DIM_0*LUT_ADDR_WIDTH-1:0] data_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready,
    output logic [DATA_IN_0_PARALLELISM_DIM_0-1:0] sat_flags,
    input  logic sat_clear,
    output logic [SAT_CNT_WIDTH-1:0] sat_count
);

    localparam int W   = DATA_IN_0_PRECISION_0;
    localparam int PAR = DATA_IN_0_PARALLELISM_DIM_0;
    localparam int A   = LUT_ADDR_WIDTH;
    localparam int SH  = DATA_IN_0_PRECISION_1 - LUT_ADDR_FRAC;
    localparam int PW  = $clog2(PAR + 1);
    localparam int CW  = SAT_CNT_WIDTH + PW;

    // Address range expressed at input width so the compare is exact.
    localparam logic signed [W-1:0] SAT_MAX =
        {{(W - A + 1){1'b0}}, {(A - 1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN =
        {{(W - A + 1){1'b1}}, {(A - 1){1'b0}}};
    localparam logic [SAT_CNT_WIDTH-1:0] CNT_MAX = '1;

    generate
        if (LUT_ADDR_FRAC > DATA_IN_0_PRECISION_1) begin : g_bad_frac
            $error("LUT_ADDR_FRAC must not exceed DATA_IN_0_PRECISION_1");
        end
        if (A < 2 || A > W) begin : g_bad_addr
            $error("LUT_ADDR_WIDTH must be in [2, DATA_IN_0_PRECISION_0]");
        end
    endgenerate

    logic           s1_valid;
    logic           s2_valid;
    logic           s2_ready;
    logic           s1_adv;
    logic           in_xfer;
    logic           out_xfer;
    logic [PAR*W-1:0] s1_data;
    logic [PAR*W-1:0] s1_shift;
    logic [PAR*A-1:0] s2_addr;
    logic [PAR-1:0]   s2_flag;
    logic [CW-1:0]    cnt_base;
    logic [CW-1:0]    cnt_inc;
    logic [CW-1:0]    cnt_sum;
    logic [SAT_CNT_WIDTH-1:0] cnt_next;

    function automatic logic [PW-1:0] popcount(input logic [PAR-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < PAR; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    // Handshake: ready never depends on data_in_0_valid.
    assign s2_ready         = !s2_valid || data_out_0_ready;
    assign data_in_0_ready  = !s1_valid || s2_ready;
    assign in_xfer          = data_in_0_valid && data_in_0_ready;
    assign s1_adv           = s1_valid && s2_ready;
    assign out_xfer         = s2_valid && data_out_0_ready;
    assign data_out_0_valid = s2_valid;

    // Per-element datapath: floor shift ahead of S1, clamp ahead of S2.
    genvar g;
    generate
        for (g = 0; g < PAR; g++) begin : g_elem
            logic signed [W-1:0] in_elem;
            logic signed [W-1:0] s1_elem;
            logic                hi;
            logic                lo;

            assign in_elem = data_in_0[g*W +: W];
            assign s1_shift[g*W +: W] = in_elem >>> SH;

            assign s1_elem = s1_data[g*W +: W];
            assign hi = s1_elem > SAT_MAX;
            assign lo = s1_elem < SAT_MIN;
            assign s2_addr[g*A +: A] = hi ? SAT_MAX[A-1:0] :
                                       lo ? SAT_MIN[A-1:0] :
                                       s1_elem[A-1:0];
            assign s2_flag[g] = hi | lo;
        end
    endgenerate

    // Stage occupancy flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid <= 1'b1;
            end else if (out_xfer) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // S1 captures the shifted beat on each input transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_data <= '0;
        end else if (in_xfer) begin
            s1_data <= s1_shift;
        end
    end

    // S2 captures clamped addresses; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_0 <= '0;
            sat_flags  <= '0;
        end else if (s1_adv) begin
            data_out_0 <= s2_addr;
            sat_flags  <= s2_flag;
        end
    end

    // Next clamp count: clear wins but still counts the beat leaving now.
    always_comb begin
        cnt_base = sat_clear ? '0 : CW'(sat_count);
        cnt_inc  = out_xfer ? CW'(popcount(sat_flags)) : '0;
        cnt_sum  = cnt_base + cnt_inc;
        if (cnt_sum > CW'(CNT_MAX)) begin
            cnt_next = CNT_MAX;
        end else begin
            cnt_next = cnt_sum[SAT_CNT_WIDTH-1:0];
        end
    end

    // Saturating clamp counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count <= '0;
        end else begin
            sat_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_elu_lut_index.sv
// Bench for elu_lut_index: directed spec cases plus a randomized
// valid/ready run against a floor-divide-and-clamp reference model.
module tb_elu_lut_index;

    localparam int W   = 16;
    localparam int F   = 8;
    localparam int PAR = 4;
    localparam int A   = 2;
    localparam int AF  = 0;

    logic        clk;
    logic        rst;
    logic [63:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  flags;
    logic        sat_clear;
    logic [15:0] sat_count;

    logic [63:0] c_data;
    logic        c_valid;
    logic        c_in_ready;
    logic [7:0]  c_out;
    logic        c_out_valid;
    logic        c_ready;
    logic [3:0]  c_flags;
    logic        c_clear;
    logic [3:0]  c_count;

    int n_tests;
    int n_fail;

    elu_lut_index u_dut (
        .clk(clk), .rst(rst),
        .data_in_0(data_in), .data_in_0_valid(in_valid),
        .data_in_0_ready(in_ready),
        .data_out_0(data_out), .data_out_0_valid(out_valid),
        .data_out_0_ready(out_ready),
        .sat_flags(flags), .sat_clear(sat_clear), .sat_count(sat_count)
    );

    elu_lut_index #(.SAT_CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .data_in_0(c_data), .data_in_0_valid(c_valid),
        .data_in_0_ready(c_in_ready),
        .data_out_0(c_out), .data_out_0_valid(c_out_valid),
        .data_out_0_ready(c_ready),
        .sat_flags(c_flags), .sat_clear(c_clear), .sat_count(c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value / 2^(F-AF) rounded toward -inf, then clamp to A bits.
    function automatic logic [11:0] model(input logic [63:0] din);
        logic [7:0] o;
        logic [3:0] fl;
        int v, d, q, mx, mn;
        o = '0;
        fl = '0;
        d = 1 << (F - AF);
        mx = (1 << (A - 1)) - 1;
        mn = -(1 << (A - 1));
        for (int i = 0; i < PAR; i++) begin
            v = int'($signed(din[i*W +: W]));
            if (v >= 0) q = v / d;
            else q = -((-v + d - 1) / d);
            if (q > mx) begin
                q = mx;
                fl[i] = 1'b1;
            end else if (q < mn) begin
                q = mn;
                fl[i] = 1'b1;
            end
            o[i*A +: A] = q[A-1:0];
        end
        return {fl, o};
    endfunction

    function automatic logic [63:0] pack(input logic [15:0] e0,
        input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [63:0] gen();
        logic [63:0] r;
        logic [15:0] e;
        for (int i = 0; i < PAR; i++) begin
            if ($urandom_range(0, 1) == 1)
                e = 16'($urandom_range(0, 1023)) - 16'd512;
            else
                e = 16'($urandom);
            r[i*W +: W] = e;
        end
        return r;
    endfunction

    task automatic test_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid: got %b expected 0", out_valid);
        end
        n_tests++;
        if (sat_count !== 16'd0 || data_out !== 8'd0 || flags !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_regs: got cnt=%h out=%h flg=%h expected 0",
                     sat_count, data_out, flags);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b expected 1", in_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release: got v=%b r=%b expected v=0 r=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic one_beat(input string nm, input logic [63:0] d,
                            input logic [7:0] eo, input logic [3:0] ef,
                            input logic [15:0] ecnt);
        @(negedge clk);
        data_in = d;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready: got %b expected 1", nm, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_lat1: got valid %b expected 0", nm, out_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== eo || flags !== ef) begin
            n_fail++;
            $display("FAIL %s_out: got v=%b d=%b f=%b expected v=1 d=%b f=%b",
                     nm, out_valid, data_out, flags, eo, ef);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (sat_count !== ecnt || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_cnt: got cnt=%0d v=%b expected cnt=%0d v=0",
                     nm, sat_count, out_valid, ecnt);
        end
    endtask

    task automatic test_basic();
        one_beat("basic", pack(16'h0100, 16'h0180, 16'hFF80, 16'h0000),
                 8'b00_11_01_01, 4'b0000, 16'd0);
    endtask

    task automatic test_saturation();
        one_beat("sat", pack(16'h0500, 16'hF000, 16'h0100, 16'hFE00),
                 8'b10_01_10_01, 4'b0011, 16'd2);
    endtask

    task automatic test_back_pressure();
        logic [63:0] b[4];
        logic [11:0] e[4];
        logic [11:0] got[$];
        logic [11:0] held;
        int idx;
        bit seen, unstable, gap, started;
        for (int i = 0; i < 4; i++) begin
            b[i] = gen();
            e[i] = model(b[i]);
        end
        idx = 0;
        seen = 0;
        unstable = 0;
        held = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            data_in = b[idx];
            in_valid = 1'b1;
            #1;
            if (out_valid) begin
                if (!seen) begin
                    held = {flags, data_out};
                    seen = 1;
                end else if ({flags, data_out} !== held) begin
                    unstable = 1;
                end
            end
            if (in_ready) idx++;
        end
        n_tests++;
        if (idx != 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: got %0d beats rdy=%b expected 2 rdy=0",
                     idx, in_ready);
        end
        n_tests++;
        if (!seen || unstable || held !== e[0]) begin
            n_fail++;
            $display("FAIL bp_stable: got %h unstable=%0d expected %h",
                     held, unstable, e[0]);
        end
        gap = 0;
        started = 0;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (idx < 4) begin
                data_in = b[idx];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                got.push_back({flags, data_out});
                started = 1;
            end else if (started) begin
                gap = 1;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (got.size() != 4 || gap) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d beats gap=%0d expected 4 gap=0",
                     got.size(), gap);
        end
        for (int i = 0; i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== e[i]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h expected %h",
                         i, got[i], e[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] sb[$];
        logic [11:0] ex;
        logic [11:0] prev_out;
        logic [63:0] cur;
        bit pending, prev_stall;
        int sent, recv, cyc;
        longint exp_cnt;
        @(negedge clk);
        in_valid = 1'b0;
        sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        exp_cnt = 0;
        pending = 0;
        prev_stall = 0;
        prev_out = '0;
        cur = '0;
        sent = 0;
        recv = 0;
        cyc = 0;
        while (recv < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < 1000) begin
                cur = gen();
                pending = 1;
            end
            in_valid = pending && ($urandom_range(0, 3) != 0);
            data_in = cur;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || {flags, data_out} !== prev_out) begin
                    n_fail++;
                    $display("FAIL rnd_hold: got v=%b %h expected v=1 %h",
                             out_valid, {flags, data_out}, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra: got %h expected no beat",
                             {flags, data_out});
                end else begin
                    ex = sb.pop_front();
                    exp_cnt += $countones(ex[11:8]);
                    if ({flags, data_out} !== ex) begin
                        n_fail++;
                        $display("FAIL rnd_beat%0d: got %h expected %h",
                                 recv, {flags, data_out}, ex);
                    end
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {flags, data_out};
            if (in_valid && in_ready) begin
                sb.push_back(model(cur));
                pending = 0;
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (recv != 1000) begin
            n_fail++;
            $display("FAIL rnd_timeout: got %0d beats expected 1000", recv);
        end
        if (exp_cnt > 65535) exp_cnt = 65535;
        @(negedge clk);
        #1;
        n_tests++;
        if (sat_count !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d expected %0d",
                     sat_count, exp_cnt);
        end
    endtask

    task automatic test_counter_edges();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            c_data = {4{16'h7F00}};
            c_valid = 1'b1;
        end
        @(negedge clk);
        c_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (c_count !== 4'd15) begin
            n_fail++;
            $display("FAIL cnt_stick: got %0d expected 15", c_count);
        end
        @(negedge clk);
        c_data = {4{16'h8000}};
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (c_out_valid !== 1'b1 || c_flags !== 4'hF) begin
            n_fail++;
            $display("FAIL cnt_pre: got v=%b f=%b expected v=1 f=1111",
                     c_out_valid, c_flags);
        end
        c_clear = 1'b1;
        @(negedge clk);
        c_clear = 1'b0;
        #1;
        n_tests++;
        if (c_count !== 4'd4) begin
            n_fail++;
            $display("FAIL cnt_clear_xfer: got %0d expected 4", c_count);
        end
        c_clear = 1'b1;
        @(negedge clk);
        c_clear = 1'b0;
        #1;
        n_tests++;
        if (c_count !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_clear: got %0d expected 0", c_count);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] b2;
        logic [11:0] e2;
        @(negedge clk);
        out_ready = 1'b1;
        data_in = {4{16'h7F00}};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (sat_count == 16'd0) begin
            n_fail++;
            $display("FAIL ar_pre_cnt: got %0d expected nonzero", sat_count);
        end
        @(negedge clk);
        out_ready = 1'b0;
        data_in = gen();
        in_valid = 1'b1;
        @(negedge clk);
        data_in = gen();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_pre_full: got v=%b r=%b expected v=1 r=0",
                     out_valid, in_ready);
        end
        #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || sat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL ar_immediate: got v=%b cnt=%0d expected v=0 cnt=0",
                     out_valid, sat_count);
        end
        n_tests++;
        if (in_ready !== 1'b1 || data_out !== 8'd0 || flags !== 4'd0) begin
            n_fail++;
            $display("FAIL ar_regs: got r=%b d=%h f=%h expected r=1 d=0 f=0",
                     in_ready, data_out, flags);
        end
        #1;
        rst = 1'b1;
        b2 = gen();
        e2 = model(b2);
        @(negedge clk);
        out_ready = 1'b1;
        data_in = b2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_lat1: got %b expected 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || {flags, data_out} !== e2) begin
            n_fail++;
            $display("FAIL ar_lat2: got v=%b %h expected v=1 %h",
                     out_valid, {flags, data_out}, e2);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b0;
        data_in = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sat_clear = 1'b0;
        c_data = '0;
        c_valid = 1'b0;
        c_ready = 1'b1;
        c_clear = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_back_pressure();
        test_random();
        test_counter_edges();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
